imem_line_fill_responder: RTL and testbench

- Memory-side responder for instruction-cache line refills: accepts a miss request carrying an address, reads LINE_WORDS consecutive 32-bit words from a word-wide synchronous instruction memory and returns one packed cache line.
- Sits between the cache block's miss path and the backing instruction memory, replacing the combinational 128-bit memory read with a timed, handshaked refill.

---
 rtl/imem_refill_pkg.sv | 25 ++
 rtl/imem_line_fill_responder_line_assembler.sv | 38 +++
 rtl/imem_line_fill_responder.sv | 122 ++++++++++++
 tb/tb_imem_line_fill_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_refill_pkg.sv
// Shared types and helpers for the instruction-memory line refill responder.
package imem_refill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESP
    } state_t;

    localparam int WORD_W             = 32;
    localparam int DEFAULT_LINE_WORDS = 4;
    localparam int OFF_W              = $clog2(4 * DEFAULT_LINE_WORDS);

    function automatic int off_bits(input int line_words);
        return $clog2(4 * line_words);
    endfunction

    // Clears the byte-offset bits of a line; callers zero-extend narrower addresses.
    function automatic logic [63:0] line_base(input logic [63:0] addr, input int line_words);
        logic [63:0] mask;
        mask = 64'(4 * line_words) - 64'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/imem_line_fill_responder_line_assembler.sv
// Slot-indexed line register; word slot k lands in the k-th 32-bit field from the top.
module line_assembler
    import imem_refill_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [WORD_W-1:0]            wr_data,
    output logic [WORD_W*LINE_WORDS-1:0] line
);

    logic [WORD_W*LINE_WORDS-1:0] line_q;
    logic [WORD_W*LINE_WORDS-1:0] line_d;

    always_comb begin
        line_d = line_q;
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (wr_en && (wr_idx == IDX_W'(k))) begin
                line_d[WORD_W*(LINE_WORDS-k)-1 -: WORD_W] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/imem_line_fill_responder.sv
// Instruction-cache refill responder: issues LINE_WORDS word reads to a synchronous
// memory and hands back one packed line with a valid/ready handshake.
module imem_line_fill_responder
    import imem_refill_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [WORD_W*LINE_WORDS-1:0] resp_line,
    output logic [ADDR_W-1:0]            resp_addr,
    output logic                         mem_rd_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [WORD_W-1:0]            mem_rd_data,
    output logic                         busy
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
    logic              cap_en_q, cap_en_d;
    logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;
    logic [ADDR_W-1:0] base;

    assign base = ADDR_W'(line_base(64'(req_addr), LINE_WORDS));

    // Read strobe and address are registered so memory sees them one cycle after
    // the decision; the capture pair trails them by the memory's read latency.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        mem_rd_en_d = mem_rd_en_q;
        mem_addr_d  = mem_addr_q;
        resp_addr_d = resp_addr_q;
        cap_en_d    = mem_rd_en_q;
        cap_idx_d   = issue_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = FETCH;
                    issue_cnt_d = '0;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = base;
                    resp_addr_d = base;
                end
            end
            FETCH: begin
                if (mem_rd_en_q) begin
                    if (issue_cnt_q == LAST_IDX) begin
                        mem_rd_en_d = 1'b0;
                        issue_cnt_d = '0;
                    end else begin
                        issue_cnt_d = issue_cnt_q + IDX_W'(1);
                        mem_addr_d  = mem_addr_q + ADDR_W'(4);
                    end
                end
                if (cap_en_q && (cap_idx_q == LAST_IDX)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            resp_addr_q <= '0;
            cap_en_q    <= 1'b0;
            cap_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            resp_addr_q <= resp_addr_d;
            cap_en_q    <= cap_en_d;
            cap_idx_q   <= cap_idx_d;
        end
    end

    line_assembler #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W)
    ) u_line_assembler (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cap_en_q),
        .wr_idx  (cap_idx_q),
        .wr_data (mem_rd_data),
        .line    (resp_line)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign mem_rd_en  = mem_rd_en_q;
    assign mem_addr   = mem_addr_q;
    assign resp_addr  = resp_addr_q;

endmodule

// File: tb/tb_imem_line_fill_responder.sv
// Bench for the refill responder: a 4-word and an 8-word build driven against
// a behavioural memory and line model.
module tb_imem_line_fill_responder;

    logic         clk;
    logic         rst;

    logic         req_valid4, req_ready4, resp_valid4, resp_ready4, mem_rd_en4, busy4;
    logic [31:0]  req_addr4, resp_addr4, mem_addr4, mem_rd_data4;
    logic [127:0] resp_line4;

    logic         req_valid8, req_ready8, resp_valid8, resp_ready8, mem_rd_en8, busy8;
    logic [31:0]  req_addr8, resp_addr8, mem_addr8, mem_rd_data8;
    logic [255:0] resp_line8;

    int compareCount = 0;
    int failCount    = 0;

    imem_line_fill_responder #(.LINE_WORDS(4), .ADDR_W(32)) u_dut4 (
        .clk (clk), .rst (rst),
        .req_valid (req_valid4), .req_ready (req_ready4), .req_addr (req_addr4),
        .resp_valid (resp_valid4), .resp_ready (resp_ready4),
        .resp_line (resp_line4), .resp_addr (resp_addr4),
        .mem_rd_en (mem_rd_en4), .mem_addr (mem_addr4), .mem_rd_data (mem_rd_data4),
        .busy (busy4)
    );

    imem_line_fill_responder #(.LINE_WORDS(8), .ADDR_W(32)) u_dut8 (
        .clk (clk), .rst (rst),
        .req_valid (req_valid8), .req_ready (req_ready8), .req_addr (req_addr8),
        .resp_valid (resp_valid8), .resp_ready (resp_ready8),
        .resp_line (resp_line8), .resp_addr (resp_addr8),
        .mem_rd_en (mem_rd_en8), .mem_addr (mem_addr8), .mem_rd_data (mem_rd_data8),
        .busy (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed pattern at 0x20..0x2C, a scrambled hash elsewhere.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a >= 32'h20 && a <= 32'h2C) begin
            return ((a - 32'h20) / 4 + 1) * 32'h1111_1111;
        end
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [255:0] expectLine(input logic [31:0] base, input int lw);
        logic [255:0] l;
        logic [31:0]  a;
        l = '0;
        for (int k = 0; k < lw; k++) begin
            a = base + 32'(4 * k);
            l = (l << 32) | {224'b0, memWord(a)};
        end
        return l;
    endfunction

    // Synchronous memory: data follows the strobe by one cycle, garbage otherwise.
    always @(posedge clk) begin
        mem_rd_data4 <= mem_rd_en4 ? memWord(mem_addr4) : $urandom;
        mem_rd_data8 <= mem_rd_en8 ? memWord(mem_addr8) : $urandom;
    end

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        compareCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One full refill on the 4-word build, optionally holding a second request during the fetch.
    task automatic applyStimulus(input logic [31:0] addr, input int hold,
                                 input bit inject, input logic [31:0] injectAddr);
        logic [31:0]  base, expAddr;
        logic [255:0] line;
        int guard;
        base = addr - (addr % 32'd16);
        line = expectLine(base, 4);
        req_valid4  = 1'b1;
        req_addr4   = addr;
        resp_ready4 = 1'b0;
        guard = 0;
        while (req_ready4 !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("acceptTimeout", 256'(guard < 50), 256'(1));
        @(posedge clk);
        @(negedge clk);
        req_valid4 = inject;
        req_addr4  = inject ? injectAddr : $urandom;
        for (int n = 0; n <= 4; n++) begin
            expAddr = base + 32'(4 * n);
            checkOutput("rdEn", 256'(mem_rd_en4), 256'(n < 4));
            if (n < 4) checkOutput("memAddr", 256'(mem_addr4), 256'(expAddr));
            checkOutput("respValidEarly", 256'(resp_valid4), 256'(0));
            checkOutput("reqReadyBusy", 256'(req_ready4), 256'(0));
            checkOutput("busy", 256'(busy4), 256'(1));
            @(negedge clk);
        end
        checkOutput("respValid", 256'(resp_valid4), 256'(1));
        checkOutput("respLine", 256'(resp_line4), line);
        checkOutput("respAddr", 256'(resp_addr4), 256'(base));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("holdValid", 256'(resp_valid4), 256'(1));
            checkOutput("holdLine", 256'(resp_line4), line);
            checkOutput("holdAddr", 256'(resp_addr4), 256'(base));
            checkOutput("holdReqReady", 256'(req_ready4), 256'(0));
            checkOutput("holdRdEn", 256'(mem_rd_en4), 256'(0));
        end
        resp_ready4 = 1'b1;
        @(negedge clk);
        resp_ready4 = 1'b0;
        checkOutput("postValid", 256'(resp_valid4), 256'(0));
        checkOutput("postBusy", 256'(busy4), 256'(0));
        checkOutput("postReqReady", 256'(req_ready4), 256'(1));
    endtask

    task automatic applyStimulus8(input logic [31:0] addr);
        logic [31:0]  base, expAddr;
        int guard;
        base = addr - (addr % 32'd32);
        req_valid8  = 1'b1;
        req_addr8   = addr;
        resp_ready8 = 1'b0;
        guard = 0;
        while (req_ready8 !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("acceptTimeout8", 256'(guard < 50), 256'(1));
        @(posedge clk);
        @(negedge clk);
        req_valid8 = 1'b0;
        req_addr8  = $urandom;
        for (int n = 0; n <= 8; n++) begin
            expAddr = base + 32'(4 * n);
            checkOutput("rdEn8", 256'(mem_rd_en8), 256'(n < 8));
            if (n < 8) checkOutput("memAddr8", 256'(mem_addr8), 256'(expAddr));
            checkOutput("respValidEarly8", 256'(resp_valid8), 256'(0));
            @(negedge clk);
        end
        checkOutput("respValid8", 256'(resp_valid8), 256'(1));
        checkOutput("respLine8", resp_line8, expectLine(base, 8));
        checkOutput("respAddr8", 256'(resp_addr8), 256'(base));
        resp_ready8 = 1'b1;
        @(negedge clk);
        resp_ready8 = 1'b0;
        checkOutput("postValid8", 256'(resp_valid8), 256'(0));
    endtask

    task automatic checkResetState();
        checkOutput("rstReqReady", 256'(req_ready4), 256'(1));
        checkOutput("rstRespValid", 256'(resp_valid4), 256'(0));
        checkOutput("rstBusy", 256'(busy4), 256'(0));
        checkOutput("rstRdEn", 256'(mem_rd_en4), 256'(0));
        checkOutput("rstMemAddr", 256'(mem_addr4), 256'(0));
        checkOutput("rstRespAddr", 256'(resp_addr4), 256'(0));
        checkOutput("rstRespLine", 256'(resp_line4), 256'(0));
    endtask

    initial begin
        rst = 1'b0;
        req_valid4 = 1'b0; req_addr4 = '0; resp_ready4 = 1'b0;
        req_valid8 = 1'b0; req_addr8 = '0; resp_ready8 = 1'b0;
        #12;
        checkResetState();
        checkOutput("rstBusy8", 256'(busy8), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(32'h0000_0024, 0, 1'b0, 32'h0);
        applyStimulus(32'h0000_0030, 10, 1'b0, 32'h0);
        applyStimulus(32'h0000_0080, 0, 1'b1, 32'h0000_0040);
        applyStimulus(32'h0000_0040, 0, 1'b0, 32'h0);

        // Abandon a refill after two reads have been issued.
        req_valid4 = 1'b1;
        req_addr4  = 32'h0000_0100;
        @(posedge clk);
        @(negedge clk);
        req_valid4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkResetState();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("noRespAfterReset", 256'(resp_valid4), 256'(0));
        end
        applyStimulus(32'h0000_0104, 1, 1'b0, 32'h0);

        applyStimulus(32'hFFFF_FFF8, 2, 1'b0, 32'h0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus($urandom, $urandom_range(0, 3), 1'b0, 32'h0);
        end

        applyStimulus8(32'h0000_0024);
        applyStimulus8(32'hFFFF_FFE4);
        applyStimulus8($urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
